dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one request, answers it a fixed LATENCY edges later.
// Optional feature: define DMEM_MISALIGN_ERR_EN to error-flag (and suppress) accesses with addr[1:0] != 0.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);
   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_q;
   logic [3:0]      cnt_q;
   logic            we_q;
   logic [AW-1:0]   idx_q;
   logic            mis_q;
   logic [31:0]     wdata_q;
   logic            ack_q;
   logic            err_q;
   logic [31:0]     rdata_q;
   logic [31:0]     mem_q [DEPTH_WORDS];

   logic            ready_d;
   logic            accept_d;
   logic            commit_d;
   logic            mis_d;
   logic            wr_en_d;
   logic [AW-1:0]   idx_d;

   assign ready_d  = (state_q != WAIT);
   assign accept_d = req_i && ready_d;
   assign commit_d = (state_q == WAIT) && (cnt_q == 4'd0);
   assign idx_d    = addr_i[AW+1:2];

   // Upper address bits wrap the storage; the byte offset only matters when misalignment is checked.
`ifdef DMEM_MISALIGN_ERR_EN
   logic unused_addr_bits;
   assign mis_d            = |addr_i[1:0];
   assign unused_addr_bits = ^addr_i[31:AW+2];
`else
   logic unused_addr_bits;
   assign mis_d            = 1'b0;
   assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};
`endif

   assign wr_en_d = commit_d && we_q && !mis_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         wdata_q <= 32'd0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         unique case (state_q)
            IDLE, RESP: begin
               if (accept_d) begin
                  state_q <= WAIT;
                  cnt_q   <= CNT_LOAD;
               end else begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  // Commit edge: the response becomes visible for exactly the RESP cycle.
                  state_q <= RESP;
                  ack_q   <= 1'b1;
                  err_q   <= mis_q;
                  if (!we_q && !mis_q) begin
                     rdata_q <= mem_q[idx_q];
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
         if (accept_d) begin
            we_q    <= we_i;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            wdata_q <= wdata_i;
         end
      end
   end

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge clk_i) begin
      if (wr_en_d) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign ready_o = ready_d;
   assign ack_o   = ack_q;
   assign err_o   = err_q;
   assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 3 / DEPTH 256 and LATENCY 1 / DEPTH 16) against a transaction-level model.
module tb_dmem_responder;
   localparam bit MIS_EN =
`ifdef DMEM_MISALIGN_ERR_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req [2];
   logic        we [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        ready [2];
   logic        ack [2];
   logic        err [2];
   logic [31:0] rdata [2];

   int errors = 0;
   int checks = 0;

   // Model state: one outstanding transaction per instance with edges remaining until it completes.
   bit          pend [2];
   int          rem [2];
   logic        t_we [2];
   logic [31:0] t_addr [2];
   logic [31:0] t_wd [2];
   logic        e_ack [2];
   logic        e_err [2];
   logic [31:0] e_rd [2];
   logic [31:0] mm [2][256];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut0 (
      .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
      .wdata_i(wdata[0]), .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]));

   dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
      .wdata_i(wdata[1]), .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]));

   function automatic int lat_of(input int i);
      return (i == 0) ? 3 : 1;
   endfunction

   function automatic int dep_of(input int i);
      return (i == 0) ? 256 : 16;
   endfunction

   function automatic int idx_of(input int i, input logic [31:0] a);
      return int'((a >> 2) % 32'(dep_of(i)));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input int i);
      bit rdy;
      int ix;
      rdy = !pend[i];
      e_ack[i] = 1'b0;
      e_err[i] = 1'b0;
      if (pend[i]) begin
         rem[i]--;
         if (rem[i] == 0) begin
            pend[i]  = 1'b0;
            e_ack[i] = 1'b1;
            ix = idx_of(i, t_addr[i]);
            if (MIS_EN && (t_addr[i][1:0] != 2'b00)) e_err[i] = 1'b1;
            else if (t_we[i]) mm[i][ix] = t_wd[i];
            else e_rd[i] = mm[i][ix];
         end
      end
      if (req[i] && rdy) begin
         pend[i]   = 1'b1;
         rem[i]    = lat_of(i);
         t_we[i]   = we[i];
         t_addr[i] = addr[i];
         t_wd[i]   = wdata[i];
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            pend[i]  = 1'b0;
            rem[i]   = 0;
            e_ack[i] = 1'b0;
            e_err[i] = 1'b0;
            e_rd[i]  = 32'd0;
         end else begin
            model_step(i);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(!pend[i]));
         chk($sformatf("ack%0d", i), 32'(ack[i]), 32'(e_ack[i]));
         chk($sformatf("err%0d", i), 32'(err[i]), 32'(e_err[i]));
         chk($sformatf("rdata%0d", i), rdata[i], e_rd[i]);
      end
   end

   task automatic xact(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
      int n;
      req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
      n = 0;
      while (!ready[i] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("accept_ready%0d", i), 32'(ready[i]), 32'd1);
      @(posedge clk);
      #1;
      req[i] = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!ack[i] && lat < 40);
      chk($sformatf("ack_seen%0d", i), 32'(ack[i]), 32'd1);
      rd = rdata[i];
      er = err[i];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          ack_cyc[$];
      logic [31:0] r;
      int          idx;
      int          lo;

      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
      end
      #1 rst_n = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready", 32'(ready[i]), 32'd1);
         chk("rst_ack", 32'(ack[i]), 32'd0);
         chk("rst_err", 32'(err[i]), 32'd0);
         chk("rst_rdata", rdata[i], 32'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      fork
         begin
            logic [31:0] rd0; logic er0; int l0;
            for (int k = 0; k < 256; k++) xact(0, 1'b1, 32'(k * 4), $urandom, rd0, er0, l0);
         end
         begin
            logic [31:0] rd1; logic er1; int l1;
            for (int k = 0; k < 16; k++) xact(1, 1'b1, 32'(k * 4), $urandom, rd1, er1, l1);
         end
      join

      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk("s029_wr_lat", 32'(lat), 32'd3);
      chk("s029_wr_err", 32'(er), 32'd0);
      xact(0, 1'b0, 32'h10, 32'd0, rd, er, lat);
      chk("s029_rd_lat", 32'(lat), 32'd3);
      chk("s029_rd_data", rd, 32'hDEADBEEF);

      xact(0, 1'b1, 32'h000, 32'h1, rd, er, lat);
      xact(0, 1'b0, 32'h400, 32'd0, rd, er, lat);
      chk("s031_wrap", rd, 32'h1);

      xact(1, 1'b1, 32'h8, 32'h11111111, rd, er, lat);
      xact(1, 1'b0, 32'h8, 32'd0, rd, er, lat);
      chk("s033_rd1_lat", 32'(lat), 32'd1);
      chk("s033_rd1_old", rd, 32'h11111111);
      xact(1, 1'b1, 32'h8, 32'h22222222, rd, er, lat);
      chk("s033_wr_lat", 32'(lat), 32'd1);
      chk("s033_wr_keeps_rdata", rd, 32'h11111111);
      xact(1, 1'b0, 32'h8, 32'd0, rd, er, lat);
      chk("s033_rd2_new", rd, 32'h22222222);

      xact(0, 1'b1, 32'h20, 32'h12345678, rd, er, lat);
      xact(0, 1'b1, 32'h22, 32'hCAFEF00D, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
      chk("s034_err", 32'(er), 32'd1);
      xact(0, 1'b0, 32'h20, 32'd0, rd, er, lat);
      chk("s034_word_unchanged", rd, 32'h12345678);
`else
      chk("s034_err", 32'(er), 32'd0);
      xact(0, 1'b0, 32'h20, 32'd0, rd, er, lat);
      chk("s034_word_written", rd, 32'hCAFEF00D);
`endif

      xact(0, 1'b1, 32'h20, 32'hA5A5A5A5, rd, er, lat);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h55;
      @(posedge clk);
      #1 req[0] = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("s032_no_ack", 32'(ack[0]), 32'd0);
      end
      xact(0, 1'b0, 32'h20, 32'd0, rd, er, lat);
      chk("s032_prior", rd, 32'hA5A5A5A5);

      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ack[0]) ack_cyc.push_back(c);
      end
      req[0] = 1'b0;
      chk("s030_count", 32'(ack_cyc.size()), 32'd5);
      if (ack_cyc.size() > 0) chk("s030_first", 32'(ack_cyc[0]), 32'd3);
      for (int k = 1; k < ack_cyc.size(); k++) chk("s030_gap", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
      repeat (6) @(negedge clk);

      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            r   = $urandom;
            idx = (i == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            lo  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            req[i]   = ($urandom_range(0, 3) != 0);
            we[i]    = 1'($urandom_range(0, 1));
            addr[i]  = (r & 32'hFFFFFC00) | (32'(idx) << 2) | 32'(lo);
            wdata[i] = $urandom;
         end
         if ($urandom_range(0, 249) == 0) begin
            @(posedge clk);
            #3 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      req[0] = 1'b0;
      req[1] = 1'b0;
      repeat (6) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
